// File: rtl/dly_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dly_seq_pkg
//  Description : Shared widths and FSM state encoding for the delay-load
//                sequencer (dly_load_seq) and its helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package dly_seq_pkg;

    localparam int LANE_W = 3;   // lane index width
    localparam int DLY_W  = 5;   // delay tap value width
    localparam int ST_W   = 2;   // FSM state width

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_LOAD = 2'd1;
    localparam logic [ST_W-1:0] ST_GAP  = 2'd2;
    localparam logic [ST_W-1:0] ST_SET  = 2'd3;

endpackage : dly_seq_pkg
`default_nettype wire

// File: rtl/dly_load_seq_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin arbiter. Grants the requester that was
//                not granted last when both are valid; the pointer only moves
//                when the granted request is actually accepted.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_valid[1:0]  - request valids
//                i_accept      - grant was taken this cycle
//                o_grant[1:0]  - one-hot (or zero) grant, combinational
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_valid,
    input  logic       i_accept,
    output logic [1:0] o_grant
);

    // 1 = requester 1 was granted last, so requester 0 wins a tie.
    logic r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_accept) begin
            r_last <= o_grant[1];
        end
    end

    always_comb begin
        o_grant[0] = i_valid[0] & (~i_valid[1] |  r_last);
        o_grant[1] = i_valid[1] & (~i_valid[0] | ~r_last);
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/dly_load_seq.sv
`default_nettype none
// ============================================================================
//  Module      : dly_load_seq
//  Description : Sequences ld / set strobes toward a bank of odelay_pipe lanes.
//                Two requesters are arbitrated round-robin; an accepted
//                request drives the shared delay bus, pulses ld on its lane and
//                optionally follows with a common set strobe after SET_GAP
//                idle cycles.
//  Ports       : clk, rst                 - clock, sync active-high reset
//                dly_ready                - idelay_ctrl calibration ready
//                reqN_valid/lane/delay/commit, reqN_ready - request handshakes
//                dly_data                 - shared delay bus
//                ld[NUM_LANES-1:0], set   - load / set strobes
//                busy, pending, err       - status
//  Revision    : 1.0  initial release
// ============================================================================
module dly_load_seq
    import dly_seq_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int SET_GAP   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dly_ready,
    input  logic                 req0_valid,
    input  logic [LANE_W-1:0]    req0_lane,
    input  logic [DLY_W-1:0]     req0_delay,
    input  logic                 req0_commit,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [LANE_W-1:0]    req1_lane,
    input  logic [DLY_W-1:0]     req1_delay,
    input  logic                 req1_commit,
    output logic                 req1_ready,
    output logic [DLY_W-1:0]     dly_data,
    output logic [NUM_LANES-1:0] ld,
    output logic                 set,
    output logic                 busy,
    output logic                 pending,
    output logic                 err
);

    localparam logic [LANE_W:0] c_num_lanes = (LANE_W+1)'(NUM_LANES);
    localparam logic [3:0]      c_gap_init  = (SET_GAP > 0) ? 4'(SET_GAP - 1) : 4'd0;

    logic [ST_W-1:0]      r_state;
    logic [ST_W-1:0]      w_state_nxt;
    logic [3:0]           r_gap_cnt;
    logic                 r_commit;
    logic [DLY_W-1:0]     r_dly_data;
    logic [NUM_LANES-1:0] r_ld;
    logic                 r_set;
    logic                 r_busy;
    logic                 r_pending;
    logic                 r_err;

    logic [1:0]           w_grant;
    logic [1:0]           w_ready;
    logic                 w_idle_rdy;
    logic                 w_accept;
    logic [LANE_W-1:0]    w_sel_lane;
    logic [DLY_W-1:0]     w_sel_delay;
    logic                 w_sel_commit;
    logic                 w_lane_ok;

    logic [NUM_LANES-1:0] w_ld_nxt;
    logic                 w_set_nxt;
    logic                 w_err_nxt;
    logic                 w_pending_nxt;

    // ------------------------------------------------------------------
    // Arbitration and request selection
    // ------------------------------------------------------------------
    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_valid  ({req1_valid, req0_valid}),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    // Readies are the only combinational outputs; rst masks them so nothing
    // can be handed over in the reset cycle.
    assign w_idle_rdy   = (r_state == ST_IDLE) & dly_ready & ~rst;
    assign w_ready      = w_grant & {2{w_idle_rdy}};
    assign w_accept     = |w_ready;
    assign req0_ready   = w_ready[0];
    assign req1_ready   = w_ready[1];

    assign w_sel_lane   = w_ready[1] ? req1_lane   : req0_lane;
    assign w_sel_delay  = w_ready[1] ? req1_delay  : req0_delay;
    assign w_sel_commit = w_ready[1] ? req1_commit : req0_commit;
    assign w_lane_ok    = ({1'b0, w_sel_lane} < c_num_lanes);

    // ------------------------------------------------------------------
    // State register (also holds the registered outputs and datapath)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gap_cnt  <= 4'd0;
            r_commit   <= 1'b0;
            r_dly_data <= '0;
            r_ld       <= '0;
            r_set      <= 1'b0;
            r_busy     <= 1'b0;
            r_pending  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ld      <= w_ld_nxt;
            r_set     <= w_set_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_pending <= w_pending_nxt;
            r_err     <= w_err_nxt;
            if (w_accept && w_lane_ok) begin
                r_commit   <= w_sel_commit;
                r_dly_data <= w_sel_delay;
            end
            if (r_state == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt - 4'd1;
            end else begin
                r_gap_cnt <= c_gap_init;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_lane_ok) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (!dly_ready)    w_state_nxt = ST_IDLE;
                else if (r_commit) w_state_nxt = (SET_GAP == 0) ? ST_SET : ST_GAP;
                else               w_state_nxt = ST_IDLE;
            end
            ST_GAP: begin
                if (!dly_ready)              w_state_nxt = ST_IDLE;
                else if (r_gap_cnt == 4'd0)  w_state_nxt = ST_SET;
            end
            ST_SET: begin
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: values to be registered for the next cycle. Strobes
    // are registered, so dly_ready is checked in the cycle before the
    // strobe would appear; a drop there cancels it and raises err.
    // ------------------------------------------------------------------
    always_comb begin
        w_ld_nxt      = '0;
        w_set_nxt     = 1'b0;
        w_err_nxt     = 1'b0;
        w_pending_nxt = r_pending;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_lane_ok) begin
                        for (int i = 0; i < NUM_LANES; i++) begin
                            w_ld_nxt[i] = (w_sel_lane == LANE_W'(i));
                        end
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (!dly_ready) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_pending_nxt = 1'b1;
                    w_set_nxt     = (w_state_nxt == ST_SET);
                end
            end
            ST_GAP: begin
                if (!dly_ready) w_err_nxt = 1'b1;
                else            w_set_nxt = (w_state_nxt == ST_SET);
            end
            ST_SET: begin
                if (dly_ready) w_pending_nxt = 1'b0;
                else           w_err_nxt     = 1'b1;
            end
            default: ;
        endcase
    end

    assign dly_data = r_dly_data;
    assign ld       = r_ld;
    assign set      = r_set;
    assign busy     = r_busy;
    assign pending  = r_pending;
    assign err      = r_err;

endmodule : dly_load_seq
`default_nettype wire

// File: tb/tb_dly_load_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dly_load_seq
//  Description : Directed self-checking bench for dly_load_seq
//                (NUM_LANES=4, SET_GAP=2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dly_load_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       dly_ready;
    logic       req0_valid, req1_valid;
    logic [2:0] req0_lane,  req1_lane;
    logic [4:0] req0_delay, req1_delay;
    logic       req0_commit, req1_commit;
    logic       req0_ready, req1_ready;
    logic [4:0] dly_data;
    logic [3:0] ld;
    logic       set, busy, pending, err;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    dly_load_seq #(
        .NUM_LANES (4),
        .SET_GAP   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dly_ready   (dly_ready),
        .req0_valid  (req0_valid),
        .req0_lane   (req0_lane),
        .req0_delay  (req0_delay),
        .req0_commit (req0_commit),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_lane   (req1_lane),
        .req1_delay  (req1_delay),
        .req1_commit (req1_commit),
        .req1_ready  (req1_ready),
        .dly_data    (dly_data),
        .ld          (ld),
        .set         (set),
        .busy        (busy),
        .pending     (pending),
        .err         (err)
    );

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drive0(input logic v, input logic [2:0] lane, input logic [4:0] dly, input logic cm);
        req0_valid = v; req0_lane = lane; req0_delay = dly; req0_commit = cm;
    endtask

    task automatic drive1(input logic v, input logic [2:0] lane, input logic [4:0] dly, input logic cm);
        req1_valid = v; req1_lane = lane; req1_delay = dly; req1_commit = cm;
    endtask

    initial begin
        rst = 1'b1;
        dly_ready = 1'b1;
        drive0(1'b1, 3'd0, 5'd1, 1'b0);
        drive1(1'b0, 3'd0, 5'd0, 1'b0);

        // ---------------- reset state ----------------
        tick(); tick();
        chk_val("rst_ready0", req0_ready, 0);
        chk_val("rst_ld",     ld, 0);
        chk_val("rst_set",    set, 0);
        chk_val("rst_busy",   busy, 0);
        chk_val("rst_pend",   pending, 0);
        chk_val("rst_err",    err, 0);
        chk_val("rst_data",   dly_data, 0);
        drive0(1'b0, 3'd0, 5'd0, 1'b0);
        rst = 1'b0;
        tick();

        // ---------------- single commit load, lane 2 ----------------
        drive0(1'b1, 3'd2, 5'h15, 1'b1);
        #1;
        chk_val("a_ready0", req0_ready, 1);
        chk_val("a_ready1", req1_ready, 0);
        tick();                                   // T+1
        drive0(1'b0, 3'd0, 5'd0, 1'b0);
        chk_val("a_ld_t1",   ld, 4'b0100);
        chk_val("a_data_t1", dly_data, 5'h15);
        chk_val("a_busy_t1", busy, 1);
        chk_val("a_pend_t1", pending, 0);
        chk_val("a_set_t1",  set, 0);
        tick();                                   // T+2
        chk_val("a_ld_t2",   ld, 0);
        chk_val("a_pend_t2", pending, 1);
        chk_val("a_set_t2",  set, 0);
        tick();                                   // T+3
        chk_val("a_set_t3",  set, 0);
        chk_val("a_pend_t3", pending, 1);
        drive0(1'b1, 3'd1, 5'd3, 1'b0);
        #1;
        chk_val("a_rdy_busy", req0_ready, 0);
        drive0(1'b0, 3'd0, 5'd0, 1'b0);
        tick();                                   // T+4
        chk_val("a_set_t4",  set, 1);
        chk_val("a_pend_t4", pending, 1);
        chk_val("a_ld_t4",   ld, 0);
        chk_val("a_data_t4", dly_data, 5'h15);
        tick();                                   // T+5
        chk_val("a_set_t5",  set, 0);
        chk_val("a_pend_t5", pending, 0);
        chk_val("a_busy_t5", busy, 0);

        // ---------------- round-robin alternation ----------------
        do_reset();
        drive0(1'b1, 3'd0, 5'd3, 1'b0);
        drive1(1'b1, 3'd1, 5'd7, 1'b0);
        #1;
        chk_val("rr_g0_r0", req0_ready, 1);
        chk_val("rr_g0_r1", req1_ready, 0);
        tick();
        chk_val("rr_ld0",   ld, 4'b0001);
        chk_val("rr_d0",    dly_data, 5'd3);
        chk_val("rr_load_rdy", {req1_ready, req0_ready}, 2'b00);
        tick();
        chk_val("rr_g1_r0", req0_ready, 0);
        chk_val("rr_g1_r1", req1_ready, 1);
        tick();
        chk_val("rr_ld1",   ld, 4'b0010);
        chk_val("rr_d1",    dly_data, 5'd7);
        tick();
        chk_val("rr_g2_r0", req0_ready, 1);
        chk_val("rr_g2_r1", req1_ready, 0);
        tick();
        chk_val("rr_ld2",   ld, 4'b0001);
        chk_val("rr_d2",    dly_data, 5'd3);
        drive0(1'b0, 3'd0, 5'd0, 1'b0);
        drive1(1'b0, 3'd0, 5'd0, 1'b0);
        tick();

        // ---------------- batch loads then one commit ----------------
        do_reset();
        drive0(1'b1, 3'd0, 5'd1, 1'b0);
        tick();
        drive0(1'b0, 3'd0, 5'd0, 1'b0);
        chk_val("b_ld0",   ld, 4'b0001);
        chk_val("b_pend0", pending, 0);
        tick();
        chk_val("b_pend1", pending, 1);
        drive0(1'b1, 3'd1, 5'd2, 1'b0);
        tick();
        drive0(1'b0, 3'd0, 5'd0, 1'b0);
        chk_val("b_ld1",   ld, 4'b0010);
        chk_val("b_set1",  set, 0);
        tick();
        drive0(1'b1, 3'd3, 5'd9, 1'b1);
        tick();
        drive0(1'b0, 3'd0, 5'd0, 1'b0);
        chk_val("b_ld3",   ld, 4'b1000);
        chk_val("b_pend3", pending, 1);
        tick();
        chk_val("b_set_g1", set, 0);
        tick();
        chk_val("b_set_g2", set, 0);
        tick();
        chk_val("b_set",    set, 1);
        chk_val("b_pend_s", pending, 1);
        tick();
        chk_val("b_set_off", set, 0);
        chk_val("b_pend_off", pending, 0);

        // ---------------- out-of-range lane ----------------
        drive0(1'b1, 3'd5, 5'd4, 1'b1);
        #1;
        chk_val("e_ready", req0_ready, 1);
        tick();
        drive0(1'b0, 3'd0, 5'd0, 1'b0);
        chk_val("e_err",  err, 1);
        chk_val("e_ld",   ld, 0);
        chk_val("e_busy", busy, 0);
        tick();
        chk_val("e_err_off", err, 0);
        chk_val("e_set",     set, 0);
        chk_val("e_busy2",   busy, 0);

        // ---------------- dly_ready drop during GAP ----------------
        drive0(1'b1, 3'd1, 5'h1f, 1'b1);
        tick();
        drive0(1'b0, 3'd0, 5'd0, 1'b0);
        chk_val("g_ld", ld, 4'b0010);
        tick();                                   // first GAP cycle
        chk_val("g_pend", pending, 1);
        dly_ready = 1'b0;
        tick();
        chk_val("g_err",  err, 1);
        chk_val("g_set",  set, 0);
        chk_val("g_pend2", pending, 1);
        chk_val("g_busy", busy, 0);
        drive0(1'b1, 3'd0, 5'd2, 1'b0);
        #1;
        chk_val("g_rdy_low", req0_ready, 0);
        drive0(1'b0, 3'd0, 5'd0, 1'b0);
        tick();
        chk_val("g_err_off", err, 0);
        chk_val("g_set2",    set, 0);
        chk_val("g_pend3",   pending, 1);
        dly_ready = 1'b1;
        tick();

        // ---------------- reset in GAP ----------------
        drive0(1'b1, 3'd0, 5'd6, 1'b1);
        tick();
        drive0(1'b0, 3'd0, 5'd0, 1'b0);
        chk_val("r_ld", ld, 4'b0001);
        tick();                                   // GAP
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_val("r_ld0",   ld, 0);
        chk_val("r_set0",  set, 0);
        chk_val("r_busy0", busy, 0);
        chk_val("r_pend0", pending, 0);
        chk_val("r_err0",  err, 0);
        chk_val("r_data0", dly_data, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_val("r_noset", {ld, set, err}, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_dly_load_seq
`default_nettype wire
